// File: rtl/elephant_ise_pkg.sv
// Shared constants for the Elephant ISE inverse unit: pstep1 swapmove stage table and FSM states.
// The stage table is stored in forward-pstep1 order; the inverse unit walks it from the top down.
package elephant_ise_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_STAGES = 4;

  // Forward pstep1 applies index 0 first (shift 3) and index 3 last (shift 24).
  function automatic logic [4:0] swm_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    swm_shift = 5'd3;
      2'd1:    swm_shift = 5'd6;
      2'd2:    swm_shift = 5'd12;
      default: swm_shift = 5'd24;
    endcase
  endfunction

  function automatic logic [31:0] swm_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    swm_mask = 32'h0A0A_0A0A;
      2'd1:    swm_mask = 32'h00CC_00CC;
      2'd2:    swm_mask = 32'h0000_F0F0;
      default: swm_mask = 32'h0000_00FF;
    endcase
  endfunction

  // Inverse step k (0..3) uses forward table entry 3-k.
  function automatic logic [1:0] inv_stage(input logic [2:0] k);
    inv_stage = 2'd3 - k[1:0];
  endfunction

endpackage

// File: rtl/elephant_swapmove.sv
// Single combinational swapmove stage: t=(x^(x>>s))&m; y=x^t^(t<<s).
// Zero latency, no flow control; shift and mask are selected from the pstep1 stage table.
module elephant_swapmove
  import elephant_ise_pkg::*;
(
  input  logic [31:0] x,
  input  logic [1:0]  shift_sel,
  input  logic [1:0]  mask_sel,
  output logic [31:0] y
);

  logic [4:0]  s;
  logic [31:0] m;
  logic [31:0] t;

  assign s = swm_shift(shift_sel);
  assign m = swm_mask(mask_sel);
  assign t = (x ^ (x >> s)) & m;
  assign y = x ^ t ^ (t << s);

endmodule

// File: rtl/elephant_ise_v2_inv.sv
// Inverse Elephant ISE ops (byte extract, bit-down, pstep1inv); latency 1, or 4/SWM_PER_CYC for pstep1inv.
// Valid/ready on both sides: one op in flight, result held in rd until out_ready, in_ready only in IDLE.
module elephant_ise_v2_inv
  import elephant_ise_pkg::*;
#(
  parameter int SWM_PER_CYC = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_bsrlext,
  input  logic        op_bdown,
  input  logic        op_pstep1inv,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rd
);

  state_t      state;
  logic [2:0]  ctr;
  logic [31:0] work;

  logic [2:0]  ops;
  logic        accept;
  logic        is_pstep;
  logic [4:0]  bd_sh;
  logic [31:0] quick_res;
  logic [2:0]  ctr_nxt;

  assign ops      = {op_bsrlext, op_bdown, op_pstep1inv};
  assign accept   = in_valid & in_ready & ~flush;
  assign is_pstep = (ops == 3'b001);
  // Shift amount wraps mod 32; bits pushed below bit 0 are simply lost.
  assign bd_sh    = imm - rs2[4:0];
  assign ctr_nxt  = ctr + 3'(SWM_PER_CYC);

  always_comb begin
    quick_res = 32'd0;
    case (ops)
      3'b100:  quick_res = (rs1 >> imm) & 32'h0000_00FF;
      3'b010:  quick_res = (rs1 >> bd_sh) & (32'd1 << rs2[4:0]);
      default: quick_res = 32'd0;
    endcase
  end

  // Stage chain: the accept cycle already does the first SWM_PER_CYC stages on rs1.
  logic [31:0] chain [0:SWM_PER_CYC];
  assign chain[0] = (state == IDLE) ? rs1 : work;

  for (genvar j = 0; j < SWM_PER_CYC; j++) begin : g_swm
    logic [1:0] sel;
    assign sel = inv_stage(ctr + 3'(j));
    elephant_swapmove u_swm (
      .x         (chain[j]),
      .shift_sel (sel),
      .mask_sel  (sel),
      .y         (chain[j+1])
    );
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rd        <= 32'd0;
      ctr       <= 3'd0;
      work      <= 32'd0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ctr       <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (!is_pstep) begin
              rd        <= quick_res;
              out_valid <= 1'b1;
              state     <= RESP;
            end else if (ctr_nxt == 3'(NUM_STAGES)) begin
              rd        <= chain[SWM_PER_CYC];
              out_valid <= 1'b1;
              ctr       <= 3'd0;
              state     <= RESP;
            end else begin
              work  <= chain[SWM_PER_CYC];
              ctr   <= ctr_nxt;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (ctr_nxt == 3'(NUM_STAGES)) begin
            rd        <= chain[SWM_PER_CYC];
            out_valid <= 1'b1;
            ctr       <= 3'd0;
            state     <= RESP;
          end else begin
            work <= chain[SWM_PER_CYC];
            ctr  <= ctr_nxt;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          ctr       <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elephant_ise_v2_inv.sv
// Bench for elephant_ise_v2_inv: three instances (SWM_PER_CYC 1,2,4) share stimulus
// and are compared against a plain-arithmetic reference model.
module tb_elephant_ise_v2_inv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        op_bs = 1'b0;
  logic        op_bd = 1'b0;
  logic        op_ps = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [4:0]  imm = 5'd0;

  logic        in_rdy  [3];
  logic        out_vld [3];
  logic [31:0] rd_q    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elephant_ise_v2_inv #(.SWM_PER_CYC(1)) dut1 (
    .g_clk(clk), .g_resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .op_bsrlext(op_bs), .op_bdown(op_bd), .op_pstep1inv(op_ps), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_vld[0]), .out_ready(out_ready), .rd(rd_q[0]));

  elephant_ise_v2_inv #(.SWM_PER_CYC(2)) dut2 (
    .g_clk(clk), .g_resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .op_bsrlext(op_bs), .op_bdown(op_bd), .op_pstep1inv(op_ps), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_vld[1]), .out_ready(out_ready), .rd(rd_q[1]));

  elephant_ise_v2_inv #(.SWM_PER_CYC(4)) dut4 (
    .g_clk(clk), .g_resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .op_bsrlext(op_bs), .op_bdown(op_bd), .op_pstep1inv(op_ps), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_vld[2]), .out_ready(out_ready), .rd(rd_q[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] swm(input logic [31:0] x, input int s, input logic [31:0] m);
    logic [31:0] t;
    t = (x ^ (x >> s)) & m;
    return x ^ t ^ (t << s);
  endfunction

  function automatic logic [31:0] pstep1_fwd(input logic [31:0] x);
    x = swm(x, 3,  32'h0A0A0A0A);
    x = swm(x, 6,  32'h00CC00CC);
    x = swm(x, 12, 32'h0000F0F0);
    x = swm(x, 24, 32'h000000FF);
    return x;
  endfunction

  function automatic logic [31:0] pstep1_inv(input logic [31:0] x);
    x = swm(x, 24, 32'h000000FF);
    x = swm(x, 12, 32'h0000F0F0);
    x = swm(x, 6,  32'h00CC00CC);
    x = swm(x, 3,  32'h0A0A0A0A);
    return x;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] ops, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] im);
    int sh;
    if (ops == 3'b100) return (a >> im) & 32'hFF;
    if (ops == 3'b010) begin
      sh = (int'(im) - int'(b[4:0]) + 32) % 32;
      return (a >> sh) & (32'd1 << b[4:0]);
    end
    if (ops == 3'b001) return pstep1_inv(a);
    return 32'd0;
  endfunction

  // Issue one op to all instances with out_ready high; checks result and latency of each.
  task automatic do_op(input string tag, input logic [2:0] ops, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] im, input logic [31:0] exp);
    int          lat [3];
    logic [31:0] got [3];
    int          exp_lat;
    @(negedge clk);
    {op_bs, op_bd, op_ps} = ops;
    rs1 = a; rs2 = b; imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      got[i] = 'x;
    end
    for (int n = 1; n <= 10; n++) begin
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && out_vld[i]) begin
          lat[i] = n;
          got[i] = rd_q[i];
        end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      exp_lat = (ops == 3'b001) ? (4 >> i) : 1;
      chk({tag, "_rd"}, got[i], exp);
      chk({tag, "_lat"}, 32'(lat[i]), 32'(exp_lat));
    end
    for (int n = 0; n < 10; n++) begin
      if (in_rdy[0] && in_rdy[1] && in_rdy[2]) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, a, b;
    logic [4:0]  im;
    logic [2:0]  ops;
    int          kind;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(in_rdy[i]), 32'd1);
      chk("rst_out_valid", 32'(out_vld[i]), 32'd0);
      chk("rst_rd", rd_q[i], 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);

    do_op("ps_0100", 3'b001, 32'h01000000, 32'd0, 5'd0, 32'h00000001);
    do_op("ps_ones", 3'b001, 32'hFFFFFFFF, 32'd0, 5'd0, 32'hFFFFFFFF);
    do_op("ps_zero", 3'b001, 32'h00000000, 32'd0, 5'd0, 32'h00000000);
    do_op("bs_8",    3'b100, 32'h12345678, 32'd0, 5'd8, 32'h00000056);
    do_op("bd_8_3",  3'b010, 32'h00000100, 32'd3, 5'd8, 32'h00000008);
    do_op("bd_3_8",  3'b010, 32'h00000100, 32'd8, 5'd3, 32'h00000000);
    do_op("no_op",   3'b000, 32'hDEADBEEF, 32'd1, 5'd4, 32'h00000000);
    do_op("multi",   3'b110, 32'hDEADBEEF, 32'd1, 5'd4, 32'h00000000);

    // Backpressure: result must hold for 5 stalled cycles.
    out_ready = 1'b0;
    @(negedge clk);
    {op_bs, op_bd, op_ps} = 3'b100;
    rs1 = 32'h12345678; imm = 5'd8;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_first_vld", 32'(out_vld[0]), 32'd1);
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("bp_vld", 32'(out_vld[i]), 32'd1);
        chk("bp_rd", rd_q[i], 32'h00000056);
        chk("bp_in_ready", 32'(in_rdy[i]), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rel_vld", 32'(out_vld[i]), 32'd0);
      chk("bp_rel_in_ready", 32'(in_rdy[i]), 32'd1);
    end

    do_op("bs_28", 3'b100, 32'h12345678, 32'd0, 5'd28, 32'h00000001);

    // Flush in the second EXEC cycle of the SWM_PER_CYC=1 instance.
    @(negedge clk);
    {op_bs, op_bd, op_ps} = 3'b001;
    rs1 = $urandom;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_in_ready", 32'(in_rdy[0]), 32'd1);
    chk("fl_rd_kept", rd_q[0], 32'h00000001);
    repeat (5) begin
      chk("fl_no_vld", 32'(out_vld[0]), 32'd0);
      @(negedge clk);
    end

    // Request coincident with flush must not be accepted.
    {op_bs, op_bd, op_ps} = 3'b100;
    rs1 = 32'h12345678; imm = 5'd8;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flreq_in_ready", 32'(in_rdy[i]), 32'd1);
      chk("flreq_no_vld", 32'(out_vld[i]), 32'd0);
    end
    @(negedge clk);
    chk("flreq_no_vld2", 32'(out_vld[0]), 32'd0);

    // Asynchronous reset in the middle of EXEC.
    {op_bs, op_bd, op_ps} = 3'b001;
    rs1 = 32'h01000000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_in_ready", 32'(in_rdy[i]), 32'd1);
      chk("arst_out_valid", 32'(out_vld[i]), 32'd0);
      chk("arst_rd", rd_q[i], 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Round trip through a forward pstep1 model.
    for (int k = 0; k < 3000; k++) begin
      x = $urandom;
      do_op("rt", 3'b001, pstep1_fwd(x), $urandom, 5'($urandom), x);
    end

    // Mixed random ops, including illegal op encodings.
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      b = $urandom;
      im = 5'($urandom);
      kind = $urandom_range(0, 4);
      case (kind)
        0: ops = 3'b100;
        1: ops = 3'b010;
        2: ops = 3'b001;
        3: ops = 3'b000;
        default: begin
          ops = 3'($urandom_range(0, 7));
          while ($countones(ops) < 2) ops = 3'($urandom_range(0, 7));
        end
      endcase
      do_op("rnd", ops, a, b, im, ref_result(ops, a, b, im));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
